// File: rtl/sr_lut_acc.sv
// Accumulates NUM_TERMS signed LUT terms per pixel, then rounds, shifts and biases
// the sum into a registered 32-bit result behind a valid/ready output stage.
module sr_lut_acc #(
    parameter int                 IN_W      = 8,
    parameter int                 NUM_TERMS = 4,
    parameter int                 SHIFT     = 2,
    parameter logic signed [31:0] BIAS      = 32'sd0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [31:0]     out_data,
    output logic                   err_len
);

    localparam int                     CNT_W   = $clog2(NUM_TERMS);
    localparam logic [CNT_W-1:0]       CNT_MAX = CNT_W'(NUM_TERMS - 1);
    localparam logic signed [31:0]     RND     = 32'((64'd1 << SHIFT) >> 1);

    // Round-to-nearest, arithmetic shift, then bias; all 32-bit wrapping.
    function automatic logic signed [31:0] scale_sum(input logic signed [31:0] s);
        return ((s + RND) >>> SHIFT) + BIAS;
    endfunction

    logic [CNT_W-1:0]   term_cnt_q, term_cnt_d;
    logic signed [31:0] acc_q, acc_d;
    logic               out_valid_q, out_valid_d;
    logic signed [31:0] out_data_q, out_data_d;
    logic               err_len_q, err_len_d;

    logic               cnt_last_s;
    logic               term_xfer_s;
    logic signed [31:0] term_ext_s;
    logic signed [31:0] sum_s;

    assign cnt_last_s  = (term_cnt_q == CNT_MAX);
    assign in_ready    = !(cnt_last_s && out_valid_q && !out_ready);
    assign term_xfer_s = in_valid && in_ready;
    assign term_ext_s  = 32'(in_data);
    // First term of a pixel loads the accumulator instead of adding to it.
    assign sum_s       = (term_cnt_q == '0) ? term_ext_s : (acc_q + term_ext_s);

    // Next-state for the term counter, accumulator, output stage and error pulse.
    always_comb begin
        term_cnt_d  = term_cnt_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        err_len_d   = 1'b0;

        if (term_xfer_s) begin
            acc_d     = sum_s;
            err_len_d = (in_last != cnt_last_s);
            if (cnt_last_s) begin
                term_cnt_d = '0;
            end else begin
                term_cnt_d = term_cnt_q + CNT_W'(1);
            end
        end else begin
            term_cnt_d = term_cnt_q;
        end

        if (term_xfer_s && cnt_last_s) begin
            out_valid_d = 1'b1;
            out_data_d  = scale_sum(sum_s);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            term_cnt_q  <= '0;
            acc_q       <= 32'sd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'sd0;
            err_len_q   <= 1'b0;
        end else begin
            term_cnt_q  <= term_cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_len_q   <= err_len_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign err_len   = err_len_q;

endmodule
